ten_mac_rst_sequencer: RTL and testbench
========================================

// Module: ten_mac_rst_sequencer
// PURPOSE
//  Power-up / recovery reset sequencer for the 10G MAC path. Drives ordered
//  active-high resets to GT, PCS, MAC and user logic, gated on QPLL lock and
//  PCS block lock. Retries on lock timeout and re-sequences on link loss.
//  Sits beside the 10G MAC wrapper; replaces ad-hoc per-domain reset stretchers.
// PARAMETERS
//  P_STAGE_CYCLES   16    hold cycles per reset stage (>=2)
//  P_LOCK_TIMEOUT   1024  max cycles waiting for a lock before retry (>=4)
//  P_MAX_RETRY      3     retries before sticky FAIL (1..15)
//  P_FILTER_CYCLES  8     block-lock loss filter length (used only with macro)
// PORTS
//  i_clk         in   1  system clock
//  i_rst_n       in   1  synchronous, active-low reset
//  i_qpll_lock   in   1  QPLL lock, already synchronised to i_clk
//  i_block_lock  in   1  PCS block lock, already synchronised to i_clk
//  i_soft_rst    in   1  1-cycle pulse: restart sequence, clears FAIL and retry count
//  o_gt_rst      out  1  GT reset, active high
//  o_pcs_rst     out  1  PCS reset, active high
//  o_mac_rst     out  1  MAC reset, active high
//  o_user_rst    out  1  user-logic reset, active high
//  o_ready       out  1  1 only in RUN
//  o_fail        out  1  sticky retry-exhausted flag
//  o_state       out  3  current FSM state code
//  o_retry_cnt   out  4  retries consumed since last i_rst_n or i_soft_rst
// BEHAVIOUR
//  - All outputs registered. i_rst_n=0: all four resets=1, ready=0, fail=0,
//    retry_cnt=0, state=RST_ALL, timer=0.
//  - Timer: cleared on every state change, +1 per cycle, saturates.
//  - States (codes 0..6) and per-state reset outputs (gt/pcs/mac/user):
//    RST_ALL(0) 1/1/1/1: after P_STAGE_CYCLES cycles -> WAIT_QPLL.
//    WAIT_QPLL(1) 1/1/1/1: qpll_lock=1 -> REL_GT.
//    REL_GT(2) 0/1/1/1: after P_STAGE_CYCLES cycles -> WAIT_BLOCK.
//    WAIT_BLOCK(3) 0/0/1/1: block_lock=1 -> REL_MAC.
//    REL_MAC(4) 0/0/0/1: after P_STAGE_CYCLES cycles -> RUN.
//    RUN(5) 0/0/0/0, ready=1.
//    FAIL(6) 1/1/1/1, fail=1: held until i_soft_rst or i_rst_n.
//  - Exit condition: timer==P_STAGE_CYCLES-1 gives exactly P_STAGE_CYCLES
//    cycles per stage.
//  - Timeout: in WAIT_QPLL or WAIT_BLOCK with timer==P_LOCK_TIMEOUT-1 and no
//    lock: if retry_cnt<P_MAX_RETRY then retry_cnt+1 -> RST_ALL, else -> FAIL.
//  - Lock arriving in the same cycle as the timeout: lock wins, no retry.
//  - qpll_lock=0 in any state from REL_GT through RUN -> RST_ALL; retry_cnt
//    is unchanged.
//  - block_lock=0 in REL_MAC or RUN -> WAIT_BLOCK. pcs_rst stays 0 (PCS keeps
//    trying to lock). mac/user resets reassert on the next edge.
//  - i_soft_rst (any state, incl. FAIL): next cycle state=RST_ALL, fail=0,
//    retry_cnt=0. It has priority over every other transition.
//  - o_ready and the reset outputs change on the same edge as the state.
// CONFIGURATION
//  TEN_MAC_RST_LOSS_FILTER_EN:
//  - Defined: block-lock loss in RUN/REL_MAC acts only after block_lock has
//    been 0 for P_FILTER_CYCLES consecutive cycles. Any 1 clears the filter.
//  - Undefined: loss acts on the first 0 cycle and P_FILTER_CYCLES is unused.
// STRUCTURE
//  - Package ten_mac_rst_pkg holds the state codes (localparam 0..6) and the
//    per-state reset-vector constant {gt,pcs,mac,user}.
//  - Sub-module rst_seq_timer: clear/enable counter with saturation and
//    terminal-compare outputs (stage_done, timeout). Width = clog2 of the
//    larger of P_STAGE_CYCLES and P_LOCK_TIMEOUT.
//  - Top holds the FSM, the retry counter and the optional loss filter.
// TESTING
//  1. Locks tied 1 from reset release: RUN and ready=1 exactly 3*16+2 cycles
//     after i_rst_n rises; GT release precedes PCS release by 16 cycles.
//  2. qpll_lock stuck 0: three retries, each after 1024 cycles in WAIT_QPLL,
//     then FAIL with fail=1, retry_cnt=3 and all resets=1.
//  3. In FAIL, pulse i_soft_rst: next cycle state=0, fail=0, retry_cnt=0;
//     with locks=1 the sequence reaches RUN.
//  4. In RUN, drop block_lock for 1 cycle: without the macro, state=WAIT_BLOCK
//     and mac/user resets=1 next cycle. With the macro (filter=8), no change.
//  5. In RUN, drop qpll_lock: state=RST_ALL, all resets=1, retry_cnt unchanged.
//  6. Raise block_lock on the timeout cycle of WAIT_BLOCK: state goes to
//     REL_MAC and retry_cnt does not increment.
//  7. Assert i_rst_n=0 mid-REL_GT: all outputs return to reset values on the
//     next edge.

Source files
------------

// File: rtl/ten_mac_rst_sequencer_pkg.sv
// ten_mac_rst_pkg: state codes and per-state reset vectors for the 10G MAC reset sequencer
package ten_mac_rst_pkg;

    typedef enum logic [2:0] {
        ST_RST_ALL    = 3'd0,
        ST_WAIT_QPLL  = 3'd1,
        ST_REL_GT     = 3'd2,
        ST_WAIT_BLOCK = 3'd3,
        ST_REL_MAC    = 3'd4,
        ST_RUN        = 3'd5,
        ST_FAIL       = 3'd6
    } state_e;

    // {gt,pcs,mac,user} indexed by state code; the unused code 7 keeps everything in reset
    localparam logic [7:0][3:0] C_RST_VEC = {
        4'b1111, 4'b1111, 4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1111
    };

endpackage

// File: rtl/ten_mac_rst_sequencer_if.sv
// ten_mac_rst_sequencer_if: lock/soft-reset inputs and reset/status outputs of the sequencer
interface ten_mac_rst_sequencer_if;

    logic       i_qpll_lock;
    logic       i_block_lock;
    logic       i_soft_rst;
    logic       o_gt_rst;
    logic       o_pcs_rst;
    logic       o_mac_rst;
    logic       o_user_rst;
    logic       o_ready;
    logic       o_fail;
    logic [2:0] o_state;
    logic [3:0] o_retry_cnt;

    modport master (
        output i_qpll_lock, i_block_lock, i_soft_rst,
        input  o_gt_rst, o_pcs_rst, o_mac_rst, o_user_rst, o_ready, o_fail, o_state, o_retry_cnt
    );

    modport slave (
        input  i_qpll_lock, i_block_lock, i_soft_rst,
        output o_gt_rst, o_pcs_rst, o_mac_rst, o_user_rst, o_ready, o_fail, o_state, o_retry_cnt
    );

endinterface

// File: rtl/ten_mac_rst_sequencer_timer.sv
// rst_seq_timer: saturating state timer with stage-hold and lock-timeout terminal compares
module rst_seq_timer #(
    parameter int P_STAGE_CYCLES = 16,
    parameter int P_LOCK_TIMEOUT = 1024
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_stage_done,
    output logic o_timeout
);

    localparam int W = $clog2(P_STAGE_CYCLES > P_LOCK_TIMEOUT ? P_STAGE_CYCLES : P_LOCK_TIMEOUT);
    localparam logic [W-1:0] C_MAX        = '1;
    localparam logic [W-1:0] C_STAGE_LAST = W'(P_STAGE_CYCLES - 1);
    localparam logic [W-1:0] C_TO_LAST    = W'(P_LOCK_TIMEOUT - 1);

    logic [W-1:0] cnt_q, cnt_d;

    // count up while enabled, hold at the top value, restart on clear
    always_comb cnt_d = i_clr ? '0 : (i_en && cnt_q != C_MAX) ? cnt_q + W'(1) : cnt_q;

    // timer register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign o_stage_done = cnt_q == C_STAGE_LAST;
    assign o_timeout    = cnt_q == C_TO_LAST;

endmodule

// File: rtl/ten_mac_rst_sequencer.sv
// ten_mac_rst_sequencer: ordered GT/PCS/MAC/user reset release gated on QPLL and block lock,
// with lock-timeout retry, sticky fail and link-loss re-sequencing.
// Define TEN_MAC_RST_LOSS_FILTER_EN to ignore block-lock drops shorter than P_FILTER_CYCLES.
module ten_mac_rst_sequencer
    import ten_mac_rst_pkg::*;
#(
    parameter int P_STAGE_CYCLES  = 16,
    parameter int P_LOCK_TIMEOUT  = 1024,
    parameter int P_MAX_RETRY     = 3,
    parameter int P_FILTER_CYCLES = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    ten_mac_rst_sequencer_if.slave   bus
);

    if (P_STAGE_CYCLES < 2 || P_LOCK_TIMEOUT < 4 || P_MAX_RETRY < 1 || P_MAX_RETRY > 15 ||
        P_FILTER_CYCLES < 1) begin : g_bad_param
        $error("ten_mac_rst_sequencer: parameter out of range");
    end

    state_e     state_q, state_d;
    logic [3:0] retry_q, retry_d;
    logic [3:0] rst_q;
    logic       ready_q, fail_q;
    logic       stage_done, timeout, blk_loss;

`ifdef TEN_MAC_RST_LOSS_FILTER_EN
    localparam int FW = $clog2(P_FILTER_CYCLES + 1);
    localparam logic [FW-1:0] C_FILT_LAST = FW'(P_FILTER_CYCLES - 1);

    logic [FW-1:0] filt_q;

    // count consecutive block-lock-low cycles; any high cycle restarts the count
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || bus.i_block_lock) filt_q <= '0;
        else if (filt_q != C_FILT_LAST)   filt_q <= filt_q + FW'(1);
    end

    assign blk_loss = !bus.i_block_lock && filt_q == C_FILT_LAST;
`else
    assign blk_loss = !bus.i_block_lock;
`endif

    rst_seq_timer #(
        .P_STAGE_CYCLES (P_STAGE_CYCLES),
        .P_LOCK_TIMEOUT (P_LOCK_TIMEOUT)
    ) u_timer (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_clr        (bus.i_soft_rst || state_d != state_q),
        .i_en         (1'b1),
        .o_stage_done (stage_done),
        .o_timeout    (timeout)
    );

    // next state and retry count; soft reset beats QPLL loss beats block loss beats progress
    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        if (bus.i_soft_rst) begin
            state_d = ST_RST_ALL;
            retry_d = '0;
        end else if (!bus.i_qpll_lock && state_q inside {ST_REL_GT, ST_WAIT_BLOCK, ST_REL_MAC, ST_RUN}) begin
            state_d = ST_RST_ALL;
        end else if (blk_loss && state_q inside {ST_REL_MAC, ST_RUN}) begin
            state_d = ST_WAIT_BLOCK;
        end else if (stage_done && state_q inside {ST_RST_ALL, ST_REL_GT, ST_REL_MAC}) begin
            state_d = state_e'(state_q + 3'd1);
        end else if ((state_q == ST_WAIT_QPLL && bus.i_qpll_lock) ||
                     (state_q == ST_WAIT_BLOCK && bus.i_block_lock)) begin
            state_d = state_e'(state_q + 3'd1);
        end else if (timeout && state_q inside {ST_WAIT_QPLL, ST_WAIT_BLOCK}) begin
            state_d = retry_q < 4'(P_MAX_RETRY) ? ST_RST_ALL : ST_FAIL;
            retry_d = retry_q < 4'(P_MAX_RETRY) ? retry_q + 4'd1 : retry_q;
        end
    end

    // state, retry count and outputs decoded from the next state so they move together
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_RST_ALL;
            retry_q <= '0;
            rst_q   <= 4'b1111;
            ready_q <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            retry_q <= retry_d;
            rst_q   <= C_RST_VEC[state_d];
            ready_q <= state_d == ST_RUN;
            fail_q  <= state_d == ST_FAIL;
        end
    end

    assign bus.o_gt_rst    = rst_q[3];
    assign bus.o_pcs_rst   = rst_q[2];
    assign bus.o_mac_rst   = rst_q[1];
    assign bus.o_user_rst  = rst_q[0];
    assign bus.o_ready     = ready_q;
    assign bus.o_fail      = fail_q;
    assign bus.o_state     = state_q;
    assign bus.o_retry_cnt = retry_q;

endmodule

// File: tb/tb_ten_mac_rst_sequencer.sv
// tb_ten_mac_rst_sequencer: directed scenarios against a cycle-count model of the reset sequencer
module tb_ten_mac_rst_sequencer;

    localparam int S = 16;
    localparam int T = 1024;
    localparam int R = 3;
    localparam int F = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    bit   started = 0;
    int   m_st = 0, m_spent = 0, m_retry = 0, m_zeros = 0;
    int   took;

    always #5 clk = ~clk;

    ten_mac_rst_sequencer_if bus();

    ten_mac_rst_sequencer #(
        .P_STAGE_CYCLES  (S),
        .P_LOCK_TIMEOUT  (T),
        .P_MAX_RETRY     (R),
        .P_FILTER_CYCLES (F)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // expected outputs straight from the per-state table: which stages are still held in reset
    function automatic logic [12:0] model_out(input int s, input int r);
        logic gt, pcs, mac, user;
        gt   = s <= 1 || s == 6;
        pcs  = s <= 2 || s == 6;
        mac  = s <= 3 || s == 6;
        user = s != 5;
        return {gt, pcs, mac, user, s == 5, s == 6, 3'(s), 4'(r)};
    endfunction

    function automatic logic [12:0] dut_out();
        return {bus.o_gt_rst, bus.o_pcs_rst, bus.o_mac_rst, bus.o_user_rst, bus.o_ready,
                bus.o_fail, bus.o_state, bus.o_retry_cnt};
    endfunction

    // model: m_spent = cycles already spent in the current state
    always @(posedge clk) begin
        int  n;
        bit  q, b, lost;
        q = bus.i_qpll_lock;
        b = bus.i_block_lock;
        if (!rst_n) begin
            m_st = 0; m_spent = 0; m_retry = 0; m_zeros = 0; started = 1;
        end else begin
            n = m_st;
`ifdef TEN_MAC_RST_LOSS_FILTER_EN
            lost = !b && m_zeros + 1 >= F;
`else
            lost = !b;
`endif
            if (bus.i_soft_rst) begin
                n = 0; m_retry = 0;
            end else if (!q && m_st >= 2 && m_st <= 5) n = 0;
            else if (lost && (m_st == 4 || m_st == 5)) n = 3;
            else if ((m_st == 0 || m_st == 2 || m_st == 4) && m_spent + 1 == S) n = m_st + 1;
            else if ((m_st == 1 && q) || (m_st == 3 && b)) n = m_st + 1;
            else if ((m_st == 1 || m_st == 3) && m_spent + 1 == T) begin
                if (m_retry < R) begin m_retry++; n = 0; end
                else n = 6;
            end
            m_spent = (n != m_st || bus.i_soft_rst) ? 0 : m_spent + 1;
            m_st = n;
            m_zeros = b ? 0 : m_zeros + 1;
        end
    end

    always @(negedge clk) if (started) check("cycle", dut_out(), model_out(m_st, m_retry));

    function automatic int probe(input int sel);
        return sel == 0 ? int'(bus.o_state) : sel == 1 ? int'(bus.o_gt_rst) :
               sel == 2 ? int'(bus.o_pcs_rst) : sel == 3 ? int'(bus.o_ready) : int'(bus.o_retry_cnt);
    endfunction

    task automatic wait_until(input string name, input int sel, input int val, input int budget, output int n);
        n = 0;
        while (probe(sel) != val && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (probe(sel) != val) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: wait budget %0d expired, got %0d expected %0d", name, budget, probe(sel), val);
        end
    endtask

    initial begin
        bus.i_qpll_lock = 1'b1;
        bus.i_block_lock = 1'b1;
        bus.i_soft_rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_values", dut_out(), {4'hF, 1'b0, 1'b0, 3'd0, 4'd0});

        // locks present from reset release
        rst_n = 1'b1;
        wait_until("gt_release", 1, 0, 100, took);
        check("gt_release_cycles", 13'(took), 13'd17);
        wait_until("pcs_release", 2, 0, 100, took);
        check("gt_to_pcs_cycles", 13'(took), 13'd16);
        wait_until("ready", 3, 1, 100, took);
        check("ready_total_cycles", 13'(took + 33), 13'd50);

        // one-cycle block-lock drop in RUN
        bus.i_block_lock = 1'b0;
        @(negedge clk);
        bus.i_block_lock = 1'b1;
`ifdef TEN_MAC_RST_LOSS_FILTER_EN
        check("blk_drop", {6'd0, bus.o_state, bus.o_pcs_rst, bus.o_mac_rst, bus.o_user_rst}, {6'd0, 3'd5, 3'b000});
        wait_until("blk_recover", 3, 1, 100, took);
        check("blk_recover_cycles", 13'(took), 13'd0);
`else
        check("blk_drop", {6'd0, bus.o_state, bus.o_pcs_rst, bus.o_mac_rst, bus.o_user_rst}, {6'd0, 3'd3, 3'b011});
        wait_until("blk_recover", 3, 1, 100, took);
        check("blk_recover_cycles", 13'(took), 13'd17);
`endif

        // QPLL never locks: three retries then sticky fail
        bus.i_qpll_lock = 1'b0;
        @(negedge clk);
        check("qpll_loss_run", dut_out(), {4'hF, 1'b0, 1'b0, 3'd0, 4'd0});
        wait_until("fail", 0, 6, 5000, took);
        check("fail_cycles", 13'(took), 13'd4160);
        check("fail_state", dut_out(), {4'hF, 1'b0, 1'b1, 3'd6, 4'd3});
        repeat (20) @(negedge clk);
        check("fail_sticky", dut_out(), {4'hF, 1'b0, 1'b1, 3'd6, 4'd3});

        // soft reset out of FAIL
        bus.i_qpll_lock = 1'b1;
        bus.i_soft_rst = 1'b1;
        @(negedge clk);
        bus.i_soft_rst = 1'b0;
        check("soft_from_fail", dut_out(), {4'hF, 1'b0, 1'b0, 3'd0, 4'd0});
        wait_until("soft_ready", 3, 1, 100, took);
        check("soft_ready_cycles", 13'(took), 13'd50);

        // one retry, then QPLL loss in RUN keeps the retry count
        bus.i_qpll_lock = 1'b0;
        @(negedge clk);
        wait_until("one_retry", 4, 1, 2000, took);
        check("one_retry_cycles", 13'(took), 13'd1040);
        bus.i_qpll_lock = 1'b1;
        wait_until("retry_ready", 3, 1, 100, took);
        check("retry_ready_cycles", 13'(took), 13'd50);
        bus.i_qpll_lock = 1'b0;
        @(negedge clk);
        bus.i_qpll_lock = 1'b1;
        check("qpll_loss_keeps_retry", dut_out(), {4'hF, 1'b0, 1'b0, 3'd0, 4'd1});
        wait_until("relock_ready", 3, 1, 100, took);

        // block lock arrives exactly on the WAIT_BLOCK timeout cycle
        bus.i_block_lock = 1'b0;
        wait_until("enter_wait_block", 0, 3, 40, took);
        repeat (T - 1) @(negedge clk);
        check("wb_before_timeout", {6'd0, bus.o_state, bus.o_retry_cnt}, {6'd0, 3'd3, 4'd1});
        bus.i_block_lock = 1'b1;
        @(negedge clk);
        check("lock_wins_timeout", {6'd0, bus.o_state, bus.o_retry_cnt}, {6'd0, 3'd4, 4'd1});
        wait_until("wb_ready", 3, 1, 100, took);

        // block lock never returns: WAIT_BLOCK timeout consumes a retry
        bus.i_block_lock = 1'b0;
        wait_until("wb_timeout_retry", 4, 2, 1200, took);
        check("wb_timeout_state", {9'd0, bus.o_state, bus.o_ready}, {9'd0, 3'd0, 1'b0});

        // synchronous reset in the middle of REL_GT
        bus.i_block_lock = 1'b1;
        bus.i_soft_rst = 1'b1;
        @(negedge clk);
        bus.i_soft_rst = 1'b0;
        wait_until("reach_rel_gt", 0, 2, 40, took);
        repeat (5) @(negedge clk);
        check("in_rel_gt", {6'd0, bus.o_state, bus.o_gt_rst, bus.o_pcs_rst, bus.o_mac_rst}, {6'd0, 3'd2, 3'b011});
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_rel_gt", dut_out(), {4'hF, 1'b0, 1'b0, 3'd0, 4'd0});
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
